// File: rtl/bench_pkg.sv
// rtl/bench_pkg.sv - shared state type, constants and helpers for the bench run controller
package bench_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RECORD,
        ST_DONE,
        ST_FAULT
    } bench_state_t;

    localparam int DEBOUNCE_125M     = 1250000;
    localparam int AUTOSTART_DEFAULT = 256;

    // ceil(log2(v)), never below 1 so the result can always size a counter
    function automatic int bench_clog2(input int unsigned v);
        int          r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int unsigned map_field(input logic [63:0] map, input int unsigned idx,
                                              input int unsigned w);
        logic [63:0] s;
        s = (map >> (idx * w)) & ((64'd1 << w) - 64'd1);
        return s[31:0];
    endfunction

endpackage

// File: rtl/bench_debounce.sv
// rtl/bench_debounce.sv - button synchroniser, debouncer and press pulse
module bench_debounce
    import bench_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_125M
) (
    input  logic sysclk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    localparam int CW = bench_clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bench_run_ctrl.sv
// rtl/bench_run_ctrl.sv - run sequencer, watchdog, winner tally and LED display
module bench_run_ctrl
    import bench_pkg::*;
#(
    parameter int                      N_COND           = 4,
    parameter int                      IDX_W            = bench_clog2(N_COND),
    parameter int                      CNT_W            = 32,
    parameter bit                      AUTOSTART_EN     = 1'b1,
    parameter int                      AUTOSTART_CYCLES = AUTOSTART_DEFAULT,
    parameter int                      DEBOUNCE_CYCLES  = DEBOUNCE_125M,
    parameter int                      TIMEOUT_CYCLES   = 2**24,
    parameter int                      N_RUNS           = 4,
    parameter logic [N_COND*IDX_W-1:0] LED_MAP          = 8'h1E,
    parameter int                      BLINK_DIV        = 2**23
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              btn_in,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [IDX_W-1:0]  eng_winner,
    input  logic [CNT_W-1:0]  eng_t_total,
    output logic [N_COND-1:0] led,
    output logic              busy,
    output logic [7:0]        run_idx,
    output logic [CNT_W-1:0]  best_total,
    output logic              timeout_flag
);

    localparam int PW = bench_clog2(AUTOSTART_CYCLES);
    localparam int WW = bench_clog2(TIMEOUT_CYCLES);
    localparam int BW = bench_clog2(BLINK_DIV);

    bench_state_t      state;
    logic              press;
    logic [PW-1:0]     pwr_cnt;
    logic              pwr_hit;
    logic [WW-1:0]     wd_cnt;
    logic [BW-1:0]     blink_cnt;
    logic [7:0]        win_cnt [N_COND];
    logic [7:0]        win_upd [N_COND];
    logic [IDX_W-1:0]  win_lat;
    logic [CNT_W-1:0]  tot_lat;
    logic [IDX_W-1:0]  arg_idx;
    logic [7:0]        arg_val;
    logic [N_COND-1:0] oh_upd;
    logic [N_COND-1:0] led_upd;
    logic              launch;
    logic              clear_seq;

    bench_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .sysclk (sysclk),
        .rst    (rst),
        .btn_in (btn_in),
        .press  (press)
    );

    // Presses only count outside START/WAIT/RECORD; PWRUP expiry clears even without autostart.
    assign launch    = (press && (state inside {ST_PWRUP, ST_IDLE, ST_DONE, ST_FAULT}))
                    || (state == ST_PWRUP && pwr_hit && AUTOSTART_EN);
    assign clear_seq = launch || (state == ST_PWRUP && pwr_hit);

    // Tally as it will look after RECORD, so DONE can show the winner in its first cycle.
    always_comb begin
        for (int i = 0; i < N_COND; i++) begin
            win_upd[i] = win_cnt[i];
            if (win_lat == IDX_W'(i) && win_cnt[i] != 8'hFF)
                win_upd[i] = win_cnt[i] + 8'd1;
        end
        arg_idx = '0;
        arg_val = win_upd[0];
        for (int i = 1; i < N_COND; i++) begin
            if (win_upd[i] > arg_val) begin
                arg_val = win_upd[i];
                arg_idx = IDX_W'(i);
            end
        end
        oh_upd          = '0;
        oh_upd[arg_idx] = 1'b1;
        for (int i = 0; i < N_COND; i++)
            led_upd[i] = oh_upd[IDX_W'(map_field(64'(LED_MAP), i, IDX_W))];
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state        <= ST_PWRUP;
            pwr_cnt      <= '0;
            pwr_hit      <= 1'b0;
            wd_cnt       <= '0;
            blink_cnt    <= '0;
            win_lat      <= '0;
            tot_lat      <= '0;
            for (int i = 0; i < N_COND; i++) win_cnt[i] <= '0;
            eng_start    <= 1'b0;
            led          <= '0;
            busy         <= 1'b0;
            run_idx      <= '0;
            best_total   <= '1;
            timeout_flag <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                ST_PWRUP: begin
                    pwr_cnt <= pwr_cnt + PW'(1);
                    pwr_hit <= (pwr_cnt == PW'(AUTOSTART_CYCLES - 1));
                    if (pwr_hit) state <= ST_IDLE;
                end
                ST_START: begin
                    state  <= ST_WAIT;
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        win_lat <= eng_winner;
                        tot_lat <= eng_t_total;
                        state   <= ST_RECORD;
                    end else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                        state        <= ST_FAULT;
                        timeout_flag <= 1'b1;
                        busy         <= 1'b0;
                        led          <= '1;
                        blink_cnt    <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WW'(1);
                    end
                end
                ST_RECORD: begin
                    win_cnt <= win_upd;
                    if (tot_lat < best_total) best_total <= tot_lat;
                    run_idx <= run_idx + 8'd1;
                    if (run_idx + 8'd1 == 8'(N_RUNS)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        led   <= led_upd;
                    end else begin
                        state     <= ST_START;
                        eng_start <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                        blink_cnt <= '0;
                        led       <= ~led;
                    end else begin
                        blink_cnt <= blink_cnt + BW'(1);
                    end
                end
                ST_IDLE, ST_DONE: ;
                default: state <= ST_PWRUP;
            endcase
            if (clear_seq) begin
                for (int i = 0; i < N_COND; i++) win_cnt[i] <= '0;
                run_idx      <= '0;
                best_total   <= '1;
                timeout_flag <= 1'b0;
            end
            if (launch) begin
                state     <= ST_START;
                eng_start <= 1'b1;
                busy      <= 1'b1;
                led       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bench_run_ctrl.sv
// tb/tb_bench_run_ctrl.sv - directed bench for bench_run_ctrl with a small engine model
module tb_bench_run_ctrl;

    logic        sysclk;
    logic        rst;
    logic        btn_in;
    logic        eng_start;
    logic        eng_done;
    logic [1:0]  eng_winner;
    logic [31:0] eng_t_total;
    logic [3:0]  led;
    logic        busy;
    logic [7:0]  run_idx;
    logic [31:0] best_total;
    logic        timeout_flag;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int starts[$];

    int          eng_delay = 10;
    int          eng_k     = 0;
    int          epoch     = 0;
    logic [1:0]  win_tab [4];
    logic [31:0] tot_tab [4];

    bench_run_ctrl #(
        .N_COND           (4),
        .CNT_W            (32),
        .AUTOSTART_EN     (1'b1),
        .AUTOSTART_CYCLES (16),
        .DEBOUNCE_CYCLES  (8),
        .TIMEOUT_CYCLES   (32),
        .N_RUNS           (4),
        .LED_MAP          (8'h1E),
        .BLINK_DIV        (4)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .btn_in       (btn_in),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_winner   (eng_winner),
        .eng_t_total  (eng_t_total),
        .led          (led),
        .busy         (busy),
        .run_idx      (run_idx),
        .best_total   (best_total),
        .timeout_flag (timeout_flag)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Cycle 0 is the cycle in which rst is released; it ends at the next rising edge.
    always @(posedge sysclk) cyc = rst ? 0 : cyc + 1;
    always @(posedge rst) epoch = epoch + 1;
    always @(negedge sysclk) if (eng_start === 1'b1) starts.push_back(cyc);

    // Engine: done in cycle s+eng_delay for a start seen in cycle s; eng_delay 0 never completes.
    initial begin
        int ep;
        int k;
        eng_done    = 1'b0;
        eng_winner  = '0;
        eng_t_total = '0;
        forever begin
            @(negedge sysclk);
            if (eng_start === 1'b1 && !rst && eng_delay != 0) begin
                ep = epoch;
                k  = eng_k;
                eng_k++;
                repeat (eng_delay) @(negedge sysclk);
                if (ep == epoch && !rst) begin
                    eng_done    = 1'b1;
                    eng_winner  = win_tab[k % 4];
                    eng_t_total = tot_tab[k % 4];
                    @(negedge sysclk);
                    eng_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic at_cycle(input int n);
        do @(negedge sysclk); while (cyc < n);
    endtask

    int r;
    int s;
    int idx;

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        win_tab = '{2'd3, 2'd3, 2'd3, 2'd3};
        tot_tab = '{32'd100, 32'd90, 32'd120, 32'd95};
        eng_delay = 10;
        repeat (3) @(negedge sysclk);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_run_idx", 64'(run_idx), 64'd0);
        check("rst_best", 64'(best_total), 64'hFFFF_FFFF);
        check("rst_timeout", 64'(timeout_flag), 64'd0);
        rst = 1'b0;

        // auto-launch: starts at 17, 29, 41, 53; DONE in 65 with winner cond3
        at_cycle(16);
        check("auto_start_early", 64'(eng_start), 64'd0);
        at_cycle(17);
        check("auto_start", 64'(eng_start), 64'd1);
        check("auto_busy", 64'(busy), 64'd1);
        at_cycle(29);
        check("auto_start2", 64'(eng_start), 64'd1);
        at_cycle(64);
        check("rec_led", 64'(led), 64'd0);
        check("rec_busy", 64'(busy), 64'd1);
        check("rec_run_idx", 64'(run_idx), 64'd3);
        at_cycle(65);
        check("auto_led", 64'(led), 64'b0010);
        check("auto_busy_done", 64'(busy), 64'd0);
        check("auto_run_idx", 64'(run_idx), 64'd4);
        check("auto_best", 64'(best_total), 64'd90);
        check("auto_starts_n", 64'(starts.size()), 64'd4);
        check("auto_start_t3", 64'(starts[3]), 64'd53);

        // 5-cycle glitch must not launch
        at_cycle(70);
        btn_in = 1'b1;
        at_cycle(75);
        btn_in = 1'b0;
        at_cycle(95);
        check("glitch_starts", 64'(starts.size()), 64'd4);
        check("glitch_led", 64'(led), 64'b0010);

        // held press: start at r+11; second press lands in WAIT and is dropped
        win_tab   = '{2'd1, 2'd2, 2'd1, 2'd2};
        tot_tab   = '{32'd500, 32'd300, 32'd400, 32'd350};
        eng_delay = 5;
        eng_k     = 0;
        r = cyc;
        btn_in = 1'b1;
        at_cycle(r + 10);
        check("btn_start_early", 64'(eng_start), 64'd0);
        at_cycle(r + 11);
        check("btn_start", 64'(eng_start), 64'd1);
        check("btn_clear_idx", 64'(run_idx), 64'd0);
        at_cycle(r + 12);
        btn_in = 1'b0;
        at_cycle(r + 24);
        btn_in = 1'b1;
        at_cycle(r + 34);
        check("busy_press_state", 64'(busy), 64'd1);
        at_cycle(r + 36);
        check("busy_press_idx", 64'(run_idx), 64'd3);
        at_cycle(r + 39);
        check("tie_led", 64'(led), 64'b0100);
        check("tie_run_idx", 64'(run_idx), 64'd4);
        check("tie_best", 64'(best_total), 64'd300);
        at_cycle(r + 40);
        btn_in = 1'b0;
        at_cycle(r + 45);
        check("busy_press_starts", 64'(starts.size()), 64'd8);
        check("busy_press_idle", 64'(busy), 64'd0);

        // done in the watchdog expiry cycle: RECORD wins, next start 34 cycles later
        at_cycle(r + 60);
        win_tab   = '{2'd0, 2'd0, 2'd0, 2'd0};
        tot_tab   = '{32'd70, 32'd80, 32'd60, 32'd65};
        eng_delay = 32;
        eng_k     = 0;
        r = cyc;
        s = r + 11;
        btn_in = 1'b1;
        at_cycle(r + 12);
        btn_in = 1'b0;
        at_cycle(s + 33);
        check("edge_no_fault", 64'(timeout_flag), 64'd0);
        at_cycle(s + 34);
        check("edge_restart", 64'(eng_start), 64'd1);
        at_cycle(s + 135);
        check("edge_busy", 64'(busy), 64'd1);
        at_cycle(s + 136);
        check("edge_done_busy", 64'(busy), 64'd0);
        check("edge_led", 64'(led), 64'b1000);
        check("edge_run_idx", 64'(run_idx), 64'd4);
        check("edge_best", 64'(best_total), 64'd60);
        check("edge_timeout", 64'(timeout_flag), 64'd0);

        // watchdog: engine silent, FAULT 32 cycles after WAIT entry, then blink
        at_cycle(s + 146);
        eng_delay = 0;
        r = cyc;
        s = r + 11;
        btn_in = 1'b1;
        at_cycle(r + 12);
        btn_in = 1'b0;
        at_cycle(s + 32);
        check("wd_pre_flag", 64'(timeout_flag), 64'd0);
        check("wd_pre_busy", 64'(busy), 64'd1);
        at_cycle(s + 33);
        check("wd_flag", 64'(timeout_flag), 64'd1);
        check("wd_busy", 64'(busy), 64'd0);
        check("wd_led_on", 64'(led), 64'hF);
        check("wd_run_idx", 64'(run_idx), 64'd0);
        at_cycle(s + 36);
        check("blink_on_end", 64'(led), 64'hF);
        at_cycle(s + 37);
        check("blink_off", 64'(led), 64'h0);
        at_cycle(s + 41);
        check("blink_on_again", 64'(led), 64'hF);

        // press from FAULT clears the flag and restarts
        at_cycle(s + 50);
        win_tab   = '{2'd2, 2'd2, 2'd2, 2'd2};
        tot_tab   = '{32'd40, 32'd30, 32'd50, 32'd45};
        eng_delay = 10;
        eng_k     = 0;
        r = cyc;
        s = r + 11;
        btn_in = 1'b1;
        at_cycle(r + 10);
        check("fault_flag_held", 64'(timeout_flag), 64'd1);
        at_cycle(r + 11);
        check("fault_restart", 64'(eng_start), 64'd1);
        check("fault_flag_clr", 64'(timeout_flag), 64'd0);
        check("fault_led_clr", 64'(led), 64'd0);
        at_cycle(r + 12);
        btn_in = 1'b0;

        // asynchronous reset in WAIT of the second run
        at_cycle(s + 14);
        check("mid_run_idx", 64'(run_idx), 64'd1);
        check("mid_best", 64'(best_total), 64'd40);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_run_idx", 64'(run_idx), 64'd0);
        check("arst_best", 64'(best_total), 64'hFFFF_FFFF);
        check("arst_led", 64'(led), 64'd0);
        check("arst_eng_start", 64'(eng_start), 64'd0);
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        idx = starts.size();
        at_cycle(16);
        check("rearm_start_early", 64'(eng_start), 64'd0);
        at_cycle(17);
        check("rearm_start", 64'(eng_start), 64'd1);
        at_cycle(19);
        check("rearm_starts_n", 64'(starts.size()), 64'(idx + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bench_run_ctrl.md
# bench_run_ctrl

Parametrised run controller for the router benchmark top level. It replaces the fixed power-up one-shot, raw button-edge retrigger and hard-wired LED remap. It sequences N_RUNS back-to-back runs of a bench engine, debounces the user button, applies a per-run watchdog, tallies the per-condition winner and drives a remappable one-hot LED display. It sits between board I/O (sysclk, BTN0, LEDs) and `bench_engine`.

## Interface
- N_COND, 4: number of benchmark conditions and LEDs (≥2).
- IDX_W, $clog2(N_COND): winner index width (derived; do not override).
- CNT_W, 32: cycle-count width of engine totals.
- AUTOSTART_EN, 1: 1 = launch a sequence automatically after reset.
- AUTOSTART_CYCLES, 256: cycles from reset release to auto-launch (≥1).
- DEBOUNCE_CYCLES, 1250000: required stable cycles for a button change (10 ms @125 MHz, ≥1).
- TIMEOUT_CYCLES, 2**24: watchdog limit per run, in cycles.
- N_RUNS, 4: runs per sequence (1..255).
- LED_MAP, 8'h1E: N_COND fields of IDX_W bits. Field i is the condition shown on led[i]. The default gives led0=cond2, led1=cond3, led2=cond1, led3=cond0.
- BLINK_DIV, 2**23: half-period of the fault blink, in cycles.

Ports:
- sysclk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- btn_in, input, 1: raw asynchronous button.
- eng_start, output, 1: one-cycle start pulse to the engine.
- eng_done, input, 1: engine run complete. Sampled only in WAIT.
- eng_winner, input, IDX_W: engine winner. Valid with eng_done.
- eng_t_total, input, CNT_W: engine aggregate cycles. Valid with eng_done.
- led, output, N_COND: remapped display.
- busy, output, 1: high in START, WAIT and RECORD.
- run_idx, output, 8: completed runs in the current sequence.
- best_total, output, CNT_W: minimum eng_t_total in the current sequence.
- timeout_flag, output, 1: sticky; set on watchdog expiry.

## Operation
- **Button path.** btn_in passes through a 2-flop synchroniser into a debouncer.
  - The debouncer counter counts consecutive cycles in which the synchronised level differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Any cycle where the two levels agree also clears the counter.
  - press is a one-cycle pulse on a debounced 0→1 transition.
- **FSM states:** PWRUP, IDLE, START, WAIT, RECORD, DONE, FAULT.
- **PWRUP.** The counter increments from 0.
  - At AUTOSTART_CYCLES-1: go to START if AUTOSTART_EN=1, otherwise to IDLE. In both cases the sequence is cleared first.
  - A press seen in PWRUP launches immediately: clear, then START.
- **IDLE, DONE, FAULT.** A press clears the sequence and goes to START.
  - Clearing means: win counters = 0, run_idx = 0, best_total = all-ones, timeout_flag = 0.
- **START.** eng_start = 1 for this one cycle, then WAIT. The watchdog clears.
- **WAIT.**
  - eng_done → RECORD.
  - Otherwise, when the watchdog reaches TIMEOUT_CYCLES-1 → FAULT and set timeout_flag.
  - If eng_done arrives in the same cycle the watchdog expires, eng_done wins.
- **RECORD.**
  - win_cnt[eng_winner] += 1, saturating at 255.
  - best_total = min(best_total, latched eng_t_total).
  - run_idx += 1.
  - Next state: DONE if the new run_idx == N_RUNS, otherwise START.
  - eng_winner ≥ N_COND is ignored for the tally and the run still counts.
- **Presses while busy** (START, WAIT, RECORD) are discarded and not queued.
- **LEDs.** Internal one-hot vector `oh` drives the display: led[i] = oh[LED_MAP field i].
  - PWRUP, IDLE, START, WAIT, RECORD: oh = 0.
  - DONE: oh = one-hot of the argmax of win_cnt. Ties resolve to the lowest index.
  - FAULT: led toggles between all-ones and all-zeros every BLINK_DIV cycles, starting from all-ones. The blink bypasses the map.

## Timing
- **Reset values:** eng_start=0, led=0, busy=0, run_idx=0, best_total=all-ones, timeout_flag=0, state PWRUP, synchroniser and debounced level 0.
- **Auto-launch:** eng_start is high exactly in cycle AUTOSTART_CYCLES+1, counting the first cycle after rst deasserts as cycle 0.
- **Button latency:** with btn_in rising before edge 0 and held, eng_start is high exactly DEBOUNCE_CYCLES+3 cycles later, given the FSM is in IDLE, DONE or FAULT.
- **Per-run overhead:** eng_done in cycle t gives RECORD in t+1. Then either eng_start in t+2 (next run) or DONE with LEDs valid in t+2.
- All outputs are registered.
- rst mid-sequence aborts immediately to the reset values. The engine is reset by the same rst.

## Structure
- **Shared package `bench_pkg`:** state enum, clog2 helper, LED_MAP field extraction function, default constants (125 MHz debounce count, autostart count).
- **One sub-module, `bench_debounce`:** synchroniser, debouncer and press-pulse generator, parametrised by DEBOUNCE_CYCLES.
- FSM, watchdog, tally, argmax and LED mux live in bench_run_ctrl.

## Test plan
- **Auto-launch:** AUTOSTART_CYCLES=16, N_RUNS=2, engine model returns done 10 cycles after start with winner 3. Expect eng_start in cycles 17 and 29, then DONE with led = 4'b0010 (default map).
- **Debounce:** DEBOUNCE_CYCLES=8, AUTOSTART_EN=0. A 5-cycle glitch gives no start. A held press gives eng_start exactly 11 cycles after the input rises.
- **Watchdog:** TIMEOUT_CYCLES=32, engine never completes. Expect timeout_flag=1 and FAULT 32 cycles after WAIT entry, then led alternating 4'hF/4'h0 every BLINK_DIV cycles. A later press clears the flag and restarts.
- **Tally and ties:** N_RUNS=4, winners 1,2,1,2. Expect argmax = cond1 and led = 4'b0100. best_total equals the smallest of the four totals.
- **Simultaneous events:** eng_done in the watchdog expiry cycle gives RECORD, not FAULT. A press during WAIT is ignored and run_idx is unaffected.
- **Reset mid-run:** rst asserted in WAIT. Outputs return to reset values asynchronously, and the auto-launch repeats after release.
